// File: rtl/elliot_derivative_if.sv
// rtl/elliot_derivative_if.sv - start/end_signal operand and result bundle for elliot_derivative
interface elliot_derivative_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] x;
  logic             start;
  logic [WIDTH-1:0] y;
  logic             end_signal;
  logic             busy;

  modport master (output x, start, input y, end_signal, busy);
  modport slave  (input x, start, output y, end_signal, busy);
endinterface

// File: rtl/elliot_derivative.sv
// rtl/elliot_derivative.sv - iterative g = 2/(1+|x|)^2 via shift-add square then restoring divide
module elliot_derivative #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input logic                clk,
  input logic                rst_n,
  elliot_derivative_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int RW = PW + 1;
  localparam int CW = $clog2(WIDTH);
  // Numerator 2^(3*FRAC+1) is divided in as a preloaded remainder plus WIDTH zero bits.
  localparam logic [RW-1:0] REM_INIT = RW'(1) << (3 * FRAC + 1 - WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state, state_next;
  logic [PW-1:0]    mcand, prod;
  logic [WIDTH-1:0] mplier, quot, y_q;
  logic [RW-1:0]    rem;
  logic [CW-1:0]    cnt;
  logic             end_q;

  logic [WIDTH-1:0] mag, dval;
  logic [RW-1:0]    rem_shift, rem_diff;
  logic             q_bit, last;

  always_comb begin
    mag       = bus.x[WIDTH-1] ? (~bus.x + WIDTH'(1)) : bus.x;
    dval      = mag + (WIDTH'(1) << FRAC);
    rem_shift = {rem[RW-2:0], 1'b0};
    rem_diff  = rem_shift - {1'b0, prod};
    // rem < prod always holds, so the difference magnitude never reaches the sign bit.
    q_bit     = ~rem_diff[RW-1];
    last      = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_next = state;
    bus.busy   = (state != IDLE);
    case (state)
      IDLE:    if (bus.start) state_next = MUL;
      MUL:     if (last) state_next = DIV;
      DIV:     if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      quot   <= '0;
      rem    <= '0;
      cnt    <= '0;
      y_q    <= '0;
      end_q  <= 1'b0;
    end else begin
      state <= state_next;
      end_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= PW'(dval);
            mplier <= dval;
            prod   <= '0;
            cnt    <= '0;
          end
        end
        MUL: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= last ? '0 : cnt + CW'(1);
          if (last) begin
            rem  <= REM_INIT;
            quot <= '0;
          end
        end
        DIV: begin
          rem  <= q_bit ? rem_diff : rem_shift;
          quot <= {quot[WIDTH-2:0], q_bit};
          cnt  <= last ? '0 : cnt + CW'(1);
          if (last) begin
            y_q   <= {quot[WIDTH-2:0], q_bit};
            end_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.y          = y_q;
  assign bus.end_signal = end_q;
endmodule
